pc_predictor: RTL

Parametrised fetch-PC generator for the 5-stage RISC-V pipeline.
- Owns the PC register and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Predicts next PC in IF; resolves and repairs mispredictions from EX with a redirect/flush.
- Keeps saturating branch and mispredict statistics counters.

---
 rtl/pc_pkg.sv | 31 +++
 rtl/btb_array.sv | 76 +++++++
 rtl/pc_predictor.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
// Shared types and helpers for the fetch-PC predictor:
//   ctr_t          : 2-bit saturating direction counter encoding
//   sat_ctr_update : one saturating step of a counter toward the resolved
//                    branch direction
// -----------------------------------------------------------------------------
package pc_pkg;

  // Strongly/weakly not-taken, weakly/strongly taken. Bit 1 is the prediction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  // Move the counter one step toward the resolved direction, sticking at the
  // ends instead of wrapping.
  function automatic ctr_t sat_ctr_update(input ctr_t ctr, input logic taken);
    ctr_t nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != ST) nxt = ctr_t'(ctr + 2'd1);
    end else begin
      if (ctr != SNT) nxt = ctr_t'(ctr - 2'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/btb_array.sv
// -----------------------------------------------------------------------------
// btb_array
// Direct-mapped branch target buffer storage.
//   clock, reset_n        : clock, asynchronous active-low clear of all entries
//   fetch_idx -> fetch_*  : async read port used by the IF lookup
//   ex_idx    -> ex_*     : async read port used to fetch the current counter
//                           of the entry being updated from EX
//   wr_en, wr_idx, wr_*   : single synchronous write port (full entry write)
// Reads return the pre-write contents; a write lands at the clock edge.
// -----------------------------------------------------------------------------
module btb_array
  import pc_pkg::*;
#(
  parameter int BTB_ENTRIES = 16,
  parameter int PC_W        = 32,
  localparam int IDX_W      = $clog2(BTB_ENTRIES),
  localparam int TAG_W      = PC_W - IDX_W - 2
) (
  input  logic             clock,
  input  logic             reset_n,
  // IF lookup port
  input  logic [IDX_W-1:0] fetch_idx,
  output logic             fetch_valid,
  output logic [TAG_W-1:0] fetch_tag,
  output logic [PC_W-1:0]  fetch_target,
  output ctr_t             fetch_ctr,
  // EX counter read port
  input  logic [IDX_W-1:0] ex_idx,
  output logic             ex_valid,
  output logic [TAG_W-1:0] ex_tag,
  output ctr_t             ex_ctr,
  // write port
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [PC_W-1:0]  wr_target,
  input  ctr_t             wr_ctr
);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
    ctr_t             ctr;
  } btb_entry_t;

  btb_entry_t mem [BTB_ENTRIES];
  btb_entry_t fetch_entry;
  btb_entry_t ex_entry;

  // NOTE: the whole table is built from flops rather than a RAM macro because a
  // reset must invalidate every entry in one step; a RAM cannot be cleared
  // asynchronously. Non-blocking assignments keep same-edge readers on old data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        mem[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
      end
    end else if (wr_en) begin
      mem[wr_idx] <= '{valid: 1'b1, tag: wr_tag, target: wr_target, ctr: wr_ctr};
    end
  end

  assign fetch_entry  = mem[fetch_idx];
  assign ex_entry     = mem[ex_idx];

  assign fetch_valid  = fetch_entry.valid;
  assign fetch_tag    = fetch_entry.tag;
  assign fetch_target = fetch_entry.target;
  assign fetch_ctr    = fetch_entry.ctr;

  assign ex_valid     = ex_entry.valid;
  assign ex_tag       = ex_entry.tag;
  assign ex_ctr       = ex_entry.ctr;

endmodule

// File: rtl/pc_predictor.sv
// -----------------------------------------------------------------------------
// pc_predictor
// Fetch-PC generator for the 5-stage pipeline: PC register, BTB-based next-PC
// prediction in IF, misprediction repair from EX, and saturating statistics.
//   clock, reset_n         : clock, asynchronous active-low reset
//   pc_write               : advance the PC (0 = load-use stall)
//   fetch_pc               : current fetch PC
//   pred_taken/pred_target : same-cycle prediction for fetch_pc
//   ex_*                   : resolved control-flow info from EX, including the
//                            prediction that travelled with the instruction
//   redirect               : combinational mispredict / IF-ID flush
//   branch_count           : resolved branches and jumps (saturating)
//   mispredict_count       : redirects issued (saturating)
// -----------------------------------------------------------------------------
module pc_predictor
  import pc_pkg::*;
#(
  parameter int              XLEN        = 64,
  parameter int              PC_W        = 32,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int              STAT_W      = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              pc_write,
  output logic [PC_W-1:0]   fetch_pc,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_target,
  input  logic              ex_valid,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic              ex_is_branch,
  input  logic              ex_is_jump,
  input  logic              ex_taken,
  input  logic [XLEN-1:0]   ex_target,
  input  logic              ex_pred_taken,
  input  logic [PC_W-1:0]   ex_pred_target,
  output logic              redirect,
  output logic [STAT_W-1:0] branch_count,
  output logic [STAT_W-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  logic             f_valid;
  logic [TAG_W-1:0] f_tag;
  logic [PC_W-1:0]  f_target;
  ctr_t             f_ctr;
  logic             e_valid;
  logic [TAG_W-1:0] e_tag;
  ctr_t             e_ctr;

  logic             f_hit;
  logic             e_hit;
  logic             res;
  logic [PC_W-1:0]  correct_target;
  logic [PC_W-1:0]  correct_pc;
  ctr_t             wr_ctr;

  // Only the low PC_W bits of the EX target address the PC space.
  logic             unused_ex_target;
  assign unused_ex_target = ^ex_target;

  btb_array #(
    .BTB_ENTRIES (BTB_ENTRIES),
    .PC_W        (PC_W)
  ) u_btb (
    .clock        (clock),
    .reset_n      (reset_n),
    .fetch_idx    (fetch_pc[IDX_W+1:2]),
    .fetch_valid  (f_valid),
    .fetch_tag    (f_tag),
    .fetch_target (f_target),
    .fetch_ctr    (f_ctr),
    .ex_idx       (ex_pc[IDX_W+1:2]),
    .ex_valid     (e_valid),
    .ex_tag       (e_tag),
    .ex_ctr       (e_ctr),
    .wr_en        (res),
    .wr_idx       (ex_pc[IDX_W+1:2]),
    .wr_tag       (ex_pc[PC_W-1:IDX_W+2]),
    .wr_target    (correct_target),
    .wr_ctr       (wr_ctr)
  );

  // IF lookup: predict taken only on a tag hit with a taken-leaning counter.
  assign f_hit       = f_valid && (f_tag == fetch_pc[PC_W-1:IDX_W+2]);
  assign pred_taken  = f_hit && (f_ctr inside {WT, ST});
  assign pred_target = pred_taken ? f_target : fetch_pc + PC_W'(4);

  // EX resolution. Non-control-flow instructions never redirect, even when a
  // stale aliased BTB entry made them look predicted-taken.
  assign res            = ex_valid && (ex_is_branch || ex_is_jump);
  assign correct_target = {ex_target[PC_W-1:1], 1'b0};
  assign correct_pc     = ex_taken ? correct_target : ex_pc + PC_W'(4);
  assign redirect       = res && ((ex_taken != ex_pred_taken) ||
                                  (ex_taken && (correct_target != ex_pred_target)));

  // Counter for the entry being written. A branch that misses the BTB starts
  // from WNT, so a not-taken miss allocates as SNT and a taken miss as WT.
  assign e_hit = e_valid && (e_tag == ex_pc[PC_W-1:IDX_W+2]);

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    wr_ctr = ST;
    if (!ex_is_jump) wr_ctr = sat_ctr_update(e_hit ? e_ctr : WNT, ex_taken);
  end

  // A redirect wins over a stall: the wrong-path instruction must be replaced
  // even while the front end is otherwise frozen.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc         <= RESET_PC;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (redirect)      fetch_pc <= correct_pc;
      else if (pc_write) fetch_pc <= pred_target;

      if (res && (branch_count != '1))
        branch_count <= branch_count + STAT_W'(1);
      if (redirect && (mispredict_count != '1))
        mispredict_count <= mispredict_count + STAT_W'(1);
    end
  end

endmodule
